// File: rtl/sm_arith_pkg.sv
// Shared types for the serial sign-magnitude arithmetic blocks.
package sm_arith_pkg;

    localparam int unsigned W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    typedef enum logic {
        OP_ADD,
        OP_SUB
    } op_t;

endpackage

// File: rtl/serial_addsub_cell.sv
// One-bit full adder / full subtractor used by the serial datapath.
module serial_addsub_cell
    import sm_arith_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    input  op_t  op,
    output logic s,
    output logic cout
);

    always_comb begin
        s = a ^ b ^ cin;
        if (op == OP_ADD) begin
            cout = (a & b) | (cin & (a ^ b));
        end else begin
            cout = (~a & b) | (cin & ~(a ^ b));
        end
    end

endmodule

// File: rtl/sm_subtractor_seq.sv
// Bit-serial a-b in unsigned or sign-magnitude format, start/busy/done handshake.
module sm_subtractor_seq
    import sm_arith_pkg::*;
#(
    parameter int unsigned W     = W_DEFAULT,
    parameter int unsigned CNT_W = 4
) (
    input  logic         iClk,
    input  logic         iRst,
    input  logic         iStart,
    input  logic         iSA,
    input  logic [W-1:0] iData_a,
    input  logic [W-1:0] iData_b,
    output logic         oBusy,
    output logic         oDone,
    output logic [W:0]   oData,
    output logic         oData_C
);

    state_t           state, stateNext;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     aSh, bSh, resSh;
    logic             cf;
    logic             saR, signA;
    op_t              opR, startOp;
    logic             cellS, cellCout;
    logic [W-1:0]     magA, magB, negDiff;
    logic [W:0]       fixData;
    logic             fixC;

    serial_addsub_cell uCell (
        .a    (aSh[0]),
        .b    (bSh[0]),
        .cin  (cf),
        .op   (opR),
        .s    (cellS),
        .cout (cellCout)
    );

    assign magA = {1'b0, iData_a[W-2:0]};
    assign magB = {1'b0, iData_b[W-2:0]};

    // Opposite signs turn a-b into a magnitude addition.
    assign startOp = (iSA && (iData_a[W-1] != iData_b[W-1])) ? OP_ADD : OP_SUB;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (iStart) stateNext = CALC;
            CALC:    if (cnt == CNT_W'(W - 1)) stateNext = FIX;
            FIX:     stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        negDiff = '0 - resSh;
        fixData = '0;
        fixC    = 1'b0;
        if (!saR) begin
            fixData = {cf, resSh};
            fixC    = cf;
        end else if (opR == OP_ADD) begin
            fixData = {signA, resSh};
            fixC    = resSh[W-1];
        end else if (!cf) begin
            fixData = {signA, resSh};
        end else begin
            fixData = {~signA, negDiff};
        end
        // Suppress negative zero, including the 0x80 input encoding.
        if (saR && (fixData[W-1:0] == '0)) begin
            fixData[W] = 1'b0;
        end
    end

    // Handshake outputs are registered, so they trail the state by one cycle.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            oBusy   <= 1'b0;
            oDone   <= 1'b0;
            oData   <= '0;
            oData_C <= 1'b0;
            cnt     <= '0;
            aSh     <= '0;
            bSh     <= '0;
            resSh   <= '0;
            cf      <= 1'b0;
            saR     <= 1'b0;
            signA   <= 1'b0;
            opR     <= OP_SUB;
        end else begin
            oDone <= (state == DONE);
            oBusy <= (state == CALC) || (state == FIX);
            case (state)
                IDLE: begin
                    if (iStart) begin
                        saR   <= iSA;
                        signA <= iSA & iData_a[W-1];
                        opR   <= startOp;
                        aSh   <= iSA ? magA : iData_a;
                        bSh   <= iSA ? magB : iData_b;
                        resSh <= '0;
                        cf    <= 1'b0;
                        cnt   <= '0;
                    end
                end
                CALC: begin
                    aSh   <= aSh >> 1;
                    bSh   <= bSh >> 1;
                    resSh <= {cellS, resSh[W-1:1]};
                    cf    <= cellCout;
                    cnt   <= cnt + CNT_W'(1);
                end
                FIX: begin
                    oData   <= fixData;
                    oData_C <= fixC;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sm_subtractor_seq.sv
// Self-checking bench for sm_subtractor_seq: directed table, random ops, robustness sequences.
module tb_sm_subtractor_seq;

    typedef struct {
        logic       sa;
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] expData;
        logic       expC;
    } vec_t;

    logic       iClk = 1'b0;
    logic       iRst = 1'b1;
    logic       iStart = 1'b0;
    logic       iSA = 1'b0;
    logic [7:0] iData_a = '0;
    logic [7:0] iData_b = '0;
    logic       oBusy, oDone, oData_C;
    logic [8:0] oData;

    int checks = 0;
    int errors = 0;

    sm_subtractor_seq #(.W(8), .CNT_W(4)) dut (
        .iClk    (iClk),
        .iRst    (iRst),
        .iStart  (iStart),
        .iSA     (iSA),
        .iData_a (iData_a),
        .iData_b (iData_b),
        .oBusy   (oBusy),
        .oDone   (oDone),
        .oData   (oData),
        .oData_C (oData_C)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Arithmetic reference: evaluate the true signed/unsigned difference.
    function automatic void model(input logic sa, input logic [7:0] a, input logic [7:0] b,
                                  output logic [8:0] d, output logic c);
        int va, vb, r, mag;
        if (!sa) begin
            r = int'(a) - int'(b);
            d = 9'(r);
            c = (a < b);
        end else begin
            va  = a[7] ? -int'(a[6:0]) : int'(a[6:0]);
            vb  = b[7] ? -int'(b[6:0]) : int'(b[6:0]);
            r   = va - vb;
            mag = (r < 0) ? -r : r;
            d   = {(r < 0), 8'(mag)};
            c   = (mag > 127);
        end
    endfunction

    task automatic runOp(input logic sa, input logic [7:0] a, input logic [7:0] b, input bit perturb,
                         output logic [8:0] data, output logic c, output int doneAt, output int busyCnt);
        @(negedge iClk);
        iSA = sa; iData_a = a; iData_b = b; iStart = 1'b1;
        @(posedge iClk); #1;
        iStart = 1'b0;
        doneAt = -1;
        busyCnt = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (perturb && cyc == 3) begin
                iStart = 1'b1; iSA = ~sa;
                iData_a = 8'($urandom); iData_b = 8'($urandom);
            end
            if (perturb && cyc == 4) iStart = 1'b0;
            @(posedge iClk); #1;
            if (oBusy) busyCnt++;
            if (oDone) begin
                doneAt = cyc;
                break;
            end
        end
        data = oData;
        c = oData_C;
    endtask

    initial begin
        vec_t       vecs[7];
        logic [8:0] d, ed;
        logic       c, ec;
        int         doneAt, busyCnt;
        bit         doneSeen;

        vecs[0] = '{1'b0, 8'hC8, 8'h37, 9'h091, 1'b0};
        vecs[1] = '{1'b0, 8'h05, 8'h0A, 9'h1FB, 1'b1};
        vecs[2] = '{1'b1, 8'h03, 8'h05, 9'h102, 1'b0};
        vecs[3] = '{1'b1, 8'hE4, 8'h64, 9'h1C8, 1'b1};
        vecs[4] = '{1'b1, 8'h05, 8'h85, 9'h00A, 1'b0};
        vecs[5] = '{1'b1, 8'h87, 8'h87, 9'h000, 1'b0};
        vecs[6] = '{1'b1, 8'h80, 8'h00, 9'h000, 1'b0};

        repeat (2) @(posedge iClk);
        #1;
        check("reset_busy", 32'(oBusy), 32'd0);
        check("reset_done", 32'(oDone), 32'd0);
        check("reset_data", 32'(oData), 32'd0);
        check("reset_c", 32'(oData_C), 32'd0);
        iRst = 1'b0;

        foreach (vecs[i]) begin
            runOp(vecs[i].sa, vecs[i].a, vecs[i].b, 1'b0, d, c, doneAt, busyCnt);
            check($sformatf("vec%0d_data", i), 32'(d), 32'(vecs[i].expData));
            check($sformatf("vec%0d_c", i), 32'(c), 32'(vecs[i].expC));
            check($sformatf("vec%0d_latency", i), 32'(doneAt), 32'd10);
            check($sformatf("vec%0d_busy", i), 32'(busyCnt), 32'd9);
        end

        // Result must hold after the done pulse.
        repeat (3) @(posedge iClk);
        #1;
        check("hold_data", 32'(oData), 32'h000);
        check("hold_done", 32'(oDone), 32'd0);

        for (int n = 0; n < 40; n++) begin
            logic       sa;
            logic [7:0] a, b;
            sa = 1'($urandom_range(0, 1));
            a  = 8'($urandom);
            b  = (n % 8 == 0) ? {~a[7], a[6:0]} : 8'($urandom);
            model(sa, a, b, ed, ec);
            runOp(sa, a, b, 1'b0, d, c, doneAt, busyCnt);
            check($sformatf("rnd%0d_data sa=%0d a=%0h b=%0h", n, sa, a, b), 32'(d), 32'(ed));
            check($sformatf("rnd%0d_c", n), 32'(c), 32'(ec));
            check($sformatf("rnd%0d_latency", n), 32'(doneAt), 32'd10);
        end

        // Start pulse and operand changes during CALC are ignored.
        runOp(1'b1, 8'hE4, 8'h64, 1'b1, d, c, doneAt, busyCnt);
        check("perturb_data", 32'(d), 32'h1C8);
        check("perturb_c", 32'(c), 32'd1);
        check("perturb_latency", 32'(doneAt), 32'd10);
        repeat (15) @(posedge iClk);
        #1;
        check("perturb_no_restart", 32'(oBusy), 32'd0);

        // Reset at cycle 4 of CALC aborts the operation.
        @(negedge iClk);
        iSA = 1'b0; iData_a = 8'h33; iData_b = 8'h11; iStart = 1'b1;
        @(posedge iClk); #1;
        iStart = 1'b0;
        repeat (4) @(posedge iClk);
        #1;
        iRst = 1'b1;
        @(posedge iClk); #1;
        iRst = 1'b0;
        check("abort_busy", 32'(oBusy), 32'd0);
        check("abort_data", 32'(oData), 32'd0);
        check("abort_c", 32'(oData_C), 32'd0);
        doneSeen = 1'b0;
        for (int cyc = 0; cyc < 15; cyc++) begin
            @(posedge iClk); #1;
            if (oDone || oBusy) doneSeen = 1'b1;
        end
        check("abort_no_done", 32'(doneSeen), 32'd0);

        runOp(1'b0, 8'h33, 8'h11, 1'b0, d, c, doneAt, busyCnt);
        check("after_abort_data", 32'(d), 32'h022);
        check("after_abort_c", 32'(c), 32'd0);
        check("after_abort_latency", 32'(doneAt), 32'd10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
